// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with PC, link-register stack and synchronous ROM interface
module fetch_unit #(
    parameter int                  ADDR_W      = 16,
    parameter int                  INS_W       = 21,
    parameter int                  STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0]   RESET_PC    = 16'h0000,
    parameter logic [INS_W-1:0]    BUBBLE_INS  = 21'h1F0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load_pc,
    input  logic              load_linkreg,
    input  logic              PC_source,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic [ADDR_W-1:0] new_linkreg,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_en,
    input  logic [INS_W-1:0]  rom_data,
    output logic [INS_W-1:0]  INS,
    output logic [ADDR_W-1:0] INS_addr,
    output logic              ins_valid,
    output logic              stack_overflow,
    output logic              stack_underflow
);

    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = PTR_W + 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic              valid_q, valid_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

    logic              take;
    logic              push;
    logic [SP_W-1:0]   sp_m1;
    logic [ADDR_W-1:0] target;

    assign take  = en & valid_q & load_pc;
    assign sp_m1 = sp_q - SP_W'(1);

    always_comb begin
        pc_d         = pc_q;
        fetch_addr_d = fetch_addr_q;
        valid_d      = valid_q;
        sp_d         = sp_q;
        ovf_d        = ovf_q;
        unf_d        = unf_q;
        push         = 1'b0;
        target       = new_pc;

        if (take) begin
            if (load_linkreg) begin
                // A call into a full stack still jumps; only the return address is lost.
                if (sp_q == SP_FULL) begin
                    ovf_d = 1'b1;
                end else begin
                    push = 1'b1;
                    sp_d = sp_q + SP_W'(1);
                end
            end else if (PC_source) begin
                if (sp_q == '0) begin
                    unf_d  = 1'b1;
                    target = RESET_PC;
                end else begin
                    target = stack_q[sp_m1[PTR_W-1:0]];
                    sp_d   = sp_m1;
                end
            end
        end

        if (en) begin
            fetch_addr_d = pc_q;
            if (take) begin
                // The word already requested from ROM is the wrong path; mark its slot as a bubble.
                pc_d    = target;
                valid_d = 1'b0;
            end else begin
                pc_d    = pc_q + ADDR_W'(1);
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            fetch_addr_q <= '0;
            valid_q      <= 1'b0;
            sp_q         <= '0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            valid_q      <= valid_d;
            sp_q         <= sp_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
            if (push) begin
                stack_q[sp_q[PTR_W-1:0]] <= new_linkreg;
            end
        end
    end

    assign rom_addr        = pc_q;
    assign rom_en          = en & ~rst;
    assign INS             = valid_q ? rom_data : BUBBLE_INS;
    assign INS_addr        = fetch_addr_q;
    assign ins_valid       = valid_q;
    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed plus randomized checks of fetch_unit against a queue-based reference model
module tb_fetch_unit;

    localparam logic [20:0] BUBBLE = 21'h1F0000;
    localparam logic [15:0] RST_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst, en, load_pc, load_linkreg, PC_source;
    logic [15:0] new_pc, new_linkreg;
    logic [15:0] rom_addr;
    logic        rom_en;
    logic [20:0] rom_data;
    logic [20:0] INS;
    logic [15:0] INS_addr;
    logic        ins_valid, stack_overflow, stack_underflow;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [15:0] m_pc, m_faddr;
    logic        m_valid, m_ovf, m_unf;
    logic [15:0] m_stack [$];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst), .en(en), .load_pc(load_pc), .load_linkreg(load_linkreg),
        .PC_source(PC_source), .new_pc(new_pc), .new_linkreg(new_linkreg),
        .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
        .INS(INS), .INS_addr(INS_addr), .ins_valid(ins_valid),
        .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
    );

    function automatic logic [20:0] rom_word(input logic [15:0] a);
        return {5'b0, a} + 21'h100;
    endfunction

    always @(posedge clk) begin
        if (rom_en) rom_data <= rom_word(rom_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic r, e, lp, ll, src, input logic [15:0] np, nl);
        logic [15:0] tgt;
        if (r) begin
            m_pc = RST_PC; m_faddr = '0; m_valid = 1'b0;
            m_stack.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        end else if (e) begin
            m_faddr = m_pc;
            if (m_valid && lp) begin
                tgt = np;
                if (ll) begin
                    if (m_stack.size() == 4) m_ovf = 1'b1;
                    else m_stack.push_back(nl);
                end else if (src) begin
                    if (m_stack.size() == 0) begin
                        m_unf = 1'b1;
                        tgt = RST_PC;
                    end else begin
                        tgt = m_stack.pop_back();
                    end
                end
                m_pc = tgt;
                m_valid = 1'b0;
            end else begin
                m_pc = m_pc + 16'd1;
                m_valid = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        chk("INS", 32'(INS), 32'(m_valid ? rom_word(m_faddr) : BUBBLE));
        chk("INS_addr", 32'(INS_addr), 32'(m_faddr));
        chk("ins_valid", 32'(ins_valid), 32'(m_valid));
        chk("rom_addr", 32'(rom_addr), 32'(m_pc));
        chk("rom_en", 32'(rom_en), 32'(en & ~rst));
        chk("stack_overflow", 32'(stack_overflow), 32'(m_ovf));
        chk("stack_underflow", 32'(stack_underflow), 32'(m_unf));
    endtask

    // Inputs are driven at the falling edge; outputs are checked at the next falling edge.
    task automatic step(input logic r, e, lp, ll, src, input logic [15:0] np, nl);
        rst = r; en = e; load_pc = lp; load_linkreg = ll; PC_source = src;
        new_pc = np; new_linkreg = nl;
        @(posedge clk);
        model_edge(r, e, lp, ll, src, np, nl);
        @(negedge clk);
        check_all();
    endtask

    task automatic seq();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic redirect(input logic ll, src, input logic [15:0] np, nl);
        step(1'b0, 1'b1, 1'b1, ll, src, np, nl);
    endtask

    logic [15:0] ret_addr [5];
    logic [15:0] exp_ret;

    initial begin
        rst = 1'b1; en = 1'b0; load_pc = 1'b0; load_linkreg = 1'b0; PC_source = 1'b0;
        new_pc = '0; new_linkreg = '0;
        m_pc = RST_PC; m_faddr = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        @(negedge clk);

        // reset state
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        chk("rst_INS", 32'(INS), 32'(BUBBLE));
        chk("rst_INS_addr", 32'(INS_addr), 32'h0);
        chk("rst_valid", 32'(ins_valid), 32'h0);
        chk("rst_rom_addr", 32'(rom_addr), 32'(RST_PC));

        // sequential fetch from RESET_PC
        seq();
        chk("seq_first_addr", 32'(INS_addr), 32'h0);
        chk("seq_first_ins", 32'(INS), 32'h100);
        chk("seq_first_valid", 32'(ins_valid), 32'h1);
        repeat (3) seq();
        chk("seq_addr3", 32'(INS_addr), 32'h3);
        chk("seq_ins3", 32'(INS), 32'h103);

        // jump at 3 to 0x40
        redirect(1'b0, 1'b0, 16'h0040, 16'h0);
        chk("jump_bubble_valid", 32'(ins_valid), 32'h0);
        chk("jump_bubble_ins", 32'(INS), 32'(BUBBLE));
        seq();
        chk("jump_target", 32'(INS_addr), 32'h40);
        chk("jump_target_ins", 32'(INS), 32'h140);

        // call at 5 to 0x20, return at 0x22
        redirect(1'b0, 1'b0, 16'h0005, 16'h0);
        seq();
        chk("at5", 32'(INS_addr), 32'h5);
        redirect(1'b1, 1'b0, 16'h0020, 16'h0006);
        seq();
        chk("call_target", 32'(INS_addr), 32'h20);
        seq();
        seq();
        chk("at22", 32'(INS_addr), 32'h22);
        redirect(1'b0, 1'b1, 16'h0, 16'h0);
        chk("ret_bubble", 32'(ins_valid), 32'h0);
        seq();
        chk("ret_target", 32'(INS_addr), 32'h6);

        // five nested calls then five returns
        for (int k = 0; k < 5; k++) begin
            ret_addr[k] = INS_addr + 16'd1;
            if (k == 4) chk("ovf_before_5th", 32'(stack_overflow), 32'h0);
            redirect(1'b1, 1'b0, 16'h0200 + 16'(k * 16), ret_addr[k]);
            seq();
            chk("nested_call_target", 32'(INS_addr), 32'(16'h0200 + 16'(k * 16)));
        end
        chk("ovf_after_5th", 32'(stack_overflow), 32'h1);
        for (int j = 0; j < 5; j++) begin
            exp_ret = (j < 4) ? ret_addr[3 - j] : RST_PC;
            redirect(1'b0, 1'b1, 16'h0, 16'h0);
            seq();
            chk("nested_ret_target", 32'(INS_addr), 32'(exp_ret));
            if (j == 3) chk("unf_before_5th", 32'(stack_underflow), 32'h0);
        end
        chk("unf_after_5th", 32'(stack_underflow), 32'h1);

        // stall at 9 with an ignored load_pc pulse
        redirect(1'b0, 1'b0, 16'h0009, 16'h0);
        seq();
        chk("at9", 32'(INS_addr), 32'h9);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0077, 16'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        chk("stall_addr", 32'(INS_addr), 32'h9);
        chk("stall_ins", 32'(INS), 32'h109);
        chk("stall_rom_addr", 32'(rom_addr), 32'hA);
        seq();
        chk("resume_addr", 32'(INS_addr), 32'hA);

        // PC wrap
        redirect(1'b0, 1'b0, 16'hFFFF, 16'h0);
        seq();
        chk("at_ffff", 32'(INS_addr), 32'hFFFF);
        seq();
        chk("wrap_addr", 32'(INS_addr), 32'h0);

        // reset mid-call with sp=2 and flags set
        redirect(1'b1, 1'b0, 16'h0300, 16'h0002);
        seq();
        redirect(1'b1, 1'b0, 16'h0310, 16'h0301);
        seq();
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        chk("mid_rst_valid", 32'(ins_valid), 32'h0);
        chk("mid_rst_ovf", 32'(stack_overflow), 32'h0);
        chk("mid_rst_unf", 32'(stack_underflow), 32'h0);
        seq();
        chk("mid_rst_restart", 32'(INS_addr), 32'(RST_PC));
        redirect(1'b0, 1'b1, 16'h0, 16'h0);
        seq();
        chk("mid_rst_sp_empty", 32'(stack_underflow), 32'h1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 16'($urandom_range(0, 16'hFFFF)),
                 m_faddr + 16'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
